// File: rtl/lut4_cfg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lut4_cfg_pkg : shared types for the LUT4 configuration sequencer   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lut4_cfg_pkg;

  localparam int LUT_BITS      = 16;
  localparam int BYTES_PER_LUT = 2;

  typedef logic [LUT_BITS-1:0] truth_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lut4_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lut4_cell : 16:1 truth-table select by a 4-bit input               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lut4_cell
  import lut4_cfg_pkg::*;
(
  input  truth_t     tt,
  input  logic [3:0] sel,
  output logic       y
);

  assign y = tt[sel];

endmodule
`default_nettype wire

// File: rtl/lut4_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lut4_cfg_sequencer : byte-serial LUT4 bank loader and evaluator    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lut4_cfg_sequencer
  import lut4_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic [7:0]            cfg_byte,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  output logic                  busy,
  output logic                  configured,
  input  logic [4*NUM_LUTS-1:0] lut_in,
  output logic [NUM_LUTS-1:0]   lut_out
);

  localparam int NUM_BYTES = BYTES_PER_LUT * NUM_LUTS;
  localparam int CW        = $clog2(NUM_BYTES);

  state_t                      state;
  logic   [CW-1:0]             cnt;
  truth_t [NUM_LUTS-1:0]       shadow;
  truth_t [NUM_LUTS-1:0]       shadow_nxt;
  truth_t [NUM_LUTS-1:0]       active;
  logic   [NUM_LUTS-1:0]       lut_val;
  logic                        accept;
  logic                        last_byte;

  assign cfg_ready = (state == LOAD) && ena && !cfg_start;
  assign busy      = (state == LOAD);
  assign accept    = cfg_valid && cfg_ready;
  assign last_byte = (cnt == CW'(NUM_BYTES - 1));

  // Shadow image including the byte being accepted, so the commit edge sees it.
  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_LUTS; i++) begin
      for (int b = 0; b < BYTES_PER_LUT; b++) begin
        if (cnt == CW'(BYTES_PER_LUT * i + b)) begin
          shadow_nxt[i][8*b +: 8] = cfg_byte;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_cell
      lut4_cell u_cell (
        .tt  (active[i]),
        .sel (lut_in[4*i +: 4]),
        .y   (lut_val[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shadow     <= '0;
      active     <= '0;
      lut_out    <= '0;
      cfg_done   <= 1'b0;
      configured <= 1'b0;
    end else if (ena) begin
      cfg_done <= 1'b0;
      // Evaluates with the pre-commit table on the commit edge.
      lut_out  <= lut_val;
      case (state)
        IDLE, RUN: begin
          if (cfg_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            cnt <= '0;
          end else if (accept) begin
            shadow <= shadow_nxt;
            if (last_byte) begin
              active     <= shadow_nxt;
              state      <= RUN;
              configured <= 1'b1;
              cfg_done   <= 1'b1;
              cnt        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lut4_cfg_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lut4_cfg_sequencer : directed self-checking bench               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lut4_cfg_sequencer;

  localparam int NUM_LUTS = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ena;
  logic                  cfg_start;
  logic                  cfg_valid;
  logic [7:0]            cfg_byte;
  logic                  cfg_ready;
  logic                  cfg_done;
  logic                  busy;
  logic                  configured;
  logic [4*NUM_LUTS-1:0] lut_in;
  logic [NUM_LUTS-1:0]   lut_out;

  int n_cmp = 0;
  int n_err = 0;

  // AND4, OR4, XOR4, NOR4; byte 0 in the low bits
  logic [63:0] std_cfg = 64'h0001_6996_FFFE_8000;

  always #5 clk = ~clk;

  lut4_cfg_sequencer #(.NUM_LUTS(NUM_LUTS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_byte   (cfg_byte),
    .cfg_ready  (cfg_ready),
    .cfg_done   (cfg_done),
    .busy       (busy),
    .configured (configured),
    .lut_in     (lut_in),
    .lut_out    (lut_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    #1;
  endtask

  // Offers one byte, waits (bounded) for acceptance, then idles for gap cycles.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    cfg_valid = 1'b1;
    cfg_byte  = b;
    #1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cfg_ready) chk("ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0;
    cfg_byte = 8'h00; lut_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("rst_lut_out", 32'(lut_out), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_configured", 32'(configured), 32'd0);
    chk("rst_done", 32'(cfg_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_lut_out", 32'(lut_out), 32'h0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Back-to-back full load
    start_load();
    chk("load_busy", 32'(busy), 32'd1);
    chk("load_ready", 32'(cfg_ready), 32'd1);
    for (int k = 0; k < 8; k++) send(std_cfg[8*k +: 8], 0);
    chk("commit_done", 32'(cfg_done), 32'd1);
    chk("commit_ready", 32'(cfg_ready), 32'd0);
    chk("commit_busy", 32'(busy), 32'd0);
    chk("commit_configured", 32'(configured), 32'd1);
    chk("commit_precommit_eval", 32'(lut_out), 32'h0);
    @(negedge clk);
    chk("done_one_cycle", 32'(cfg_done), 32'd0);
    chk("full_ffff", 32'(lut_out), 32'h3);
    lut_in = 16'h0000;
    @(negedge clk);
    chk("full_0000", 32'(lut_out), 32'h8);

    // Gapped reload of the same tables
    lut_in = 16'hFFFF;
    start_load();
    for (int k = 0; k < 4; k++) send(std_cfg[8*k +: 8], 3);
    chk("gap_still_busy", 32'(busy), 32'd1);
    chk("gap_old_eval", 32'(lut_out), 32'h3);
    for (int k = 4; k < 8; k++) send(std_cfg[8*k +: 8], 3);
    chk("gap_run", 32'(busy), 32'd0);
    chk("gap_ffff", 32'(lut_out), 32'h3);
    lut_in = 16'h0000;
    @(negedge clk);
    chk("gap_0000", 32'(lut_out), 32'h8);

    // Enable freeze mid-load
    lut_in = 16'hFFFF;
    start_load();
    for (int k = 0; k < 3; k++) send(std_cfg[8*k +: 8], 0);
    ena = 1'b0; cfg_valid = 1'b1; cfg_byte = std_cfg[31:24]; lut_in = 16'h0000;
    #1;
    chk("ena_ready_low", 32'(cfg_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("ena_lut_frozen", 32'(lut_out), 32'h3);
    chk("ena_still_busy", 32'(busy), 32'd1);
    ena = 1'b1; lut_in = 16'hFFFF;
    for (int k = 3; k < 8; k++) send(std_cfg[8*k +: 8], 0);
    chk("ena_commit_done", 32'(cfg_done), 32'd1);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    chk("done_held_while_off", 32'(cfg_done), 32'd1);
    ena = 1'b1;
    @(negedge clk);
    chk("done_clears_on_ena", 32'(cfg_done), 32'd0);
    lut_in = 16'h0000;
    @(negedge clk);
    chk("ena_resume_0000", 32'(lut_out), 32'h8);

    // Reload from RUN, restart mid-load, all-ones tables
    lut_in = 16'hFFFF;
    start_load();
    for (int k = 0; k < 4; k++) send(8'hFF, 0);
    chk("reload_old_eval", 32'(lut_out), 32'h3);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_byte = 8'hFF;
    #1;
    chk("start_wins_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    cfg_start = 1'b0; cfg_valid = 1'b0;
    for (int k = 0; k < 4; k++) send(8'hFF, 0);
    chk("restart_counter", 32'(busy), 32'd1);
    chk("restart_old_eval", 32'(lut_out), 32'h3);
    for (int k = 4; k < 8; k++) send(8'hFF, 0);
    chk("reload_done", 32'(cfg_done), 32'd1);
    @(negedge clk);
    chk("ones_ffff", 32'(lut_out), 32'hF);
    lut_in = 16'h0000;
    @(negedge clk);
    chk("ones_0000", 32'(lut_out), 32'hF);
    lut_in = 16'h5A3C;
    @(negedge clk);
    chk("ones_5a3c", 32'(lut_out), 32'hF);

    // Reset mid-load after a prior commit
    lut_in = 16'hFFFF;
    start_load();
    send(8'h12, 0);
    send(8'h34, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst2_lut_out", 32'(lut_out), 32'h0);
    chk("rst2_configured", 32'(configured), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_ready", 32'(cfg_ready), 32'd0);
    @(negedge clk);
    chk("rst2_tables_clear", 32'(lut_out), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
